flash_boot_loader: RTL and testbench
====================================

FLASH_BOOT_LOADER -- requirements
Module: flash_boot_loader

Interface
REQ-001 SHALL have parameter MEM_ADDRESS_WIDTH, default 12: width of the program-memory word address.
REQ-002 SHALL have parameter FLASH_BASE, default 24'h100000: 24-bit flash byte address of the image start.
REQ-003 SHALL have parameter WORD_COUNT, default 4096: 16-bit words to copy, 1..2^MEM_ADDRESS_WIDTH.
REQ-004 SHALL have parameter SCK_DIV, default 1: SPI_SCK half-period is (SCK_DIV+1) cpu_clock cycles.
REQ-005 SHALL have parameter WAKE_CYCLES, default 64: cpu_clock cycles waited after the release-power-down command.
REQ-006 SHALL have port cpu_clock, input, 1: the only clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port SPI_CS, output, 1: flash chip select, active-low.
REQ-009 SHALL have port SPI_SCK, output, 1: flash clock, SPI mode 0.
REQ-010 SHALL have port SPI_IO0_out, output, 1: MOSI data.
REQ-011 SHALL have port SPI_IO0_config, output, 1: IO0 output enable.
REQ-012 SHALL have port SPI_IO1, input, 1: MISO data.
REQ-013 SHALL have port mem_addr, output, MEM_ADDRESS_WIDTH: program-memory write word address.
REQ-014 SHALL have port mem_data, output, 16: program-memory write data.
REQ-015 SHALL have port mem_we, output, 1: single-cycle write strobe.
REQ-016 SHALL have port cpu_reset, output, 1: active-high reset to the gk110 core.
REQ-017 SHALL have port boot_done, output, 1: image copied successfully.
REQ-018 SHALL have port boot_error, output, 1: image rejected.

Function
REQ-019 SHALL sequence the states WAKE -> WAKE_WAIT -> CMD -> DATA -> WRITE -> (DATA | DONE), plus ERROR.
REQ-020 WAKE SHALL assert SPI_CS low and shift opcode 0xAB MSB-first, then deassert SPI_CS for at least one SCK half-period.
REQ-021 WAKE_WAIT SHALL hold SPI_CS high for exactly WAKE_CYCLES cycles.
REQ-022 CMD SHALL assert SPI_CS and shift 32 bits MSB-first: opcode 0x03, then FLASH_BASE[23:0].
REQ-023 SPI_IO0_out SHALL change only on SCK falling edges (or before the first rising edge); SPI_IO1 SHALL be sampled on SCK rising edges.
REQ-024 DATA SHALL shift in 16 bits MSB-first, with the first flash byte forming bits [15:8].
REQ-025 WRITE SHALL drive mem_data and mem_addr and pulse mem_we for exactly one cycle; SCK SHALL stay low throughout WRITE.
REQ-026 mem_addr SHALL start at 0 and increment after each write; DONE SHALL be reached after word WORD_COUNT-1 is written, with no wrap.
REQ-027 SPI_CS SHALL remain low continuously from CMD through the last DATA bit, forming one streaming read.
REQ-028 On entering DONE, the block SHALL raise SPI_CS and drive SPI_SCK low, set boot_done=1 and cpu_reset=0 on the next cycle, and hold DONE until reset.
REQ-029 cpu_reset SHALL be 1 in every state except DONE.
REQ-030 SPI_IO0_config SHALL be 1 whenever SPI_CS is low, and 0 otherwise.

Reset
REQ-031 Asserting reset (low) SHALL immediately force: state WAKE with the shift counter cleared, SPI_CS=1, SPI_SCK=0, SPI_IO0_out=0, SPI_IO0_config=0, mem_addr=0, mem_data=0, mem_we=0, cpu_reset=1, boot_done=0, boot_error=0.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer; after deassertion the block SHALL restart from WAKE.

Configuration
REQ-033 When the macro BOOT_CHECKSUM_EN is defined, the block SHALL keep a 16-bit wrapping sum of all copied words, read one extra trailing word without writing it, and enter DONE if sum + trailer == 16'h0000.
REQ-034 With BOOT_CHECKSUM_EN defined and a nonzero sum + trailer, the block SHALL enter ERROR, set boot_error=1, keep cpu_reset=1 and SPI_CS=1, and stay in ERROR until reset.
REQ-035 Without BOOT_CHECKSUM_EN, boot_error SHALL be tied to 0 and no trailer word SHALL be read.

Structure
REQ-036 Package gk110_boot_pkg SHALL hold the state enum, the opcode constants FLASH_CMD_WAKE=8'hAB and FLASH_CMD_READ=8'h03, and the width of the 32-bit command word.
REQ-037 Sub-module flash_spi_shift SHALL generate SCK, the shift register, and the bit counter with start/busy/done handshakes; the FSM lives in flash_boot_loader.

Verification
REQ-038 A flash model holding 0x1234, 0xABCD at FLASH_BASE with WORD_COUNT=2 SHALL yield writes (0,0x1234) then (1,0xABCD), after which cpu_reset falls and boot_done=1.
REQ-039 The bench SHALL check that the MOSI stream equals 0xAB, then a gap of >=WAKE_CYCLES cycles with CS high, then 0x03 10 00 00 under a single low CS.
REQ-040 Asserting reset low after the 3rd write SHALL return all outputs to reset values within the same cycle, and a full reboot SHALL rewrite from address 0.
REQ-041 With SCK_DIV=3, the SCK period SHALL be 8 cycles, and mem_we SHALL be exactly one cycle wide with SCK low.
REQ-042 With BOOT_CHECKSUM_EN defined, words 0x0001, 0x0002 with trailer 0xFFFD SHALL give boot_done=1, while trailer 0x0000 SHALL give boot_error=1 with cpu_reset held at 1.

Source files
------------

// File: rtl/gk110_boot_pkg.sv
// Shared definitions for the gk110 flash boot loader: FSM state encoding,
// serial-flash opcodes and command/transfer lengths.
package gk110_boot_pkg;

    localparam int CMD_WORD_W = 32;

    localparam logic [7:0] FLASH_CMD_WAKE = 8'hAB;
    localparam logic [7:0] FLASH_CMD_READ = 8'h03;

    // Number of SCK bits per transfer type
    localparam logic [5:0] BITS_OPCODE = 6'd8;
    localparam logic [5:0] BITS_CMD    = 6'd32;
    localparam logic [5:0] BITS_WORD   = 6'd16;

    typedef enum logic [2:0] {
        ST_WAKE,
        ST_WAKE_WAIT,
        ST_CMD,
        ST_DATA,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } boot_state_t;

endpackage

// File: rtl/flash_spi_shift.sv
// SPI mode-0 shift engine: generates SCK, shifts tx_data out MSB-first on
// MOSI (changing only on SCK falling edges) and samples MISO on SCK rising
// edges. A start pulse launches an nbits transfer; done pulses for one cycle
// after the last falling edge, leaving SCK low.
module flash_spi_shift
    import gk110_boot_pkg::*;
#(
    parameter int SCK_DIV = 1
) (
    input  logic                  cpu_clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [5:0]            nbits,
    input  logic [CMD_WORD_W-1:0] tx_data,
    input  logic                  miso,
    output logic                  sck,
    output logic                  mosi,
    output logic [15:0]           rx_data,
    output logic                  busy,
    output logic                  done
);

    localparam int DIV_W = (SCK_DIV < 1) ? 1 : $clog2(SCK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV);

    logic [CMD_WORD_W-1:0] tx_shift;
    logic [5:0]            bit_cnt;
    logic [DIV_W-1:0]      div_cnt;

    // Half-period divider, SCK toggling, MOSI shift-out and MISO shift-in
    always_ff @(posedge cpu_clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset) begin
            sck      <= 1'b0;
            mosi     <= 1'b0;
            rx_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tx_shift <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                busy     <= 1'b1;
                sck      <= 1'b0;
                mosi     <= tx_data[CMD_WORD_W-1];
                tx_shift <= tx_data << 1;
                bit_cnt  <= nbits;
                div_cnt  <= '0;
            end else if (busy) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                    sck     <= ~sck;
                    if (!sck) begin
                        // rising edge: capture the flash output bit
                        rx_data <= {rx_data[14:0], miso};
                    end else begin
                        // falling edge: bit complete, present the next one
                        bit_cnt <= bit_cnt - 6'd1;
                        if (bit_cnt == 6'd1) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            mosi     <= tx_shift[CMD_WORD_W-1];
                            tx_shift <= tx_shift << 1;
                        end
                    end
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/flash_boot_loader.sv
// Boot loader for the gk110 core: wakes the SPI flash, issues one streaming
// read at FLASH_BASE and copies WORD_COUNT 16-bit words into program memory,
// holding the core in reset until the copy completes.
// Optional feature macro BOOT_CHECKSUM_EN: reads one trailing word and only
// releases the core if the wrapping word sum plus the trailer is zero.
module flash_boot_loader
    import gk110_boot_pkg::*;
#(
    parameter int          MEM_ADDRESS_WIDTH = 12,
    parameter logic [23:0] FLASH_BASE        = 24'h100000,
    parameter int          WORD_COUNT        = 4096,
    parameter int          SCK_DIV           = 1,
    parameter int          WAKE_CYCLES       = 64
) (
    input  logic                         cpu_clock,
    input  logic                         reset,
    output logic                         SPI_CS,
    output logic                         SPI_SCK,
    output logic                         SPI_IO0_out,
    output logic                         SPI_IO0_config,
    input  logic                         SPI_IO1,
    output logic [MEM_ADDRESS_WIDTH-1:0] mem_addr,
    output logic [15:0]                  mem_data,
    output logic                         mem_we,
    output logic                         cpu_reset,
    output logic                         boot_done,
    output logic                         boot_error
);

    localparam logic [MEM_ADDRESS_WIDTH-1:0] LAST_ADDR = MEM_ADDRESS_WIDTH'(WORD_COUNT - 1);
    localparam logic [15:0] WAIT_LAST = 16'(WAKE_CYCLES - 1);

    boot_state_t           state, state_next;
    logic                  issued;
    logic                  start;
    logic [5:0]            nbits;
    logic [CMD_WORD_W-1:0] tx_word;
    logic                  busy;
    logic                  done;
    logic [15:0]           rx_word;
    logic [15:0]           wait_cnt;
    logic                  is_last;

`ifdef BOOT_CHECKSUM_EN
    logic                  trailer;
    logic [15:0]           sum;
`else
    localparam logic       trailer = 1'b0;
`endif

    assign is_last = (mem_addr == LAST_ADDR);

    flash_spi_shift #(
        .SCK_DIV (SCK_DIV)
    ) u_shift (
        .cpu_clock (cpu_clock),
        .reset     (reset),
        .start     (start),
        .nbits     (nbits),
        .tx_data   (tx_word),
        .miso      (SPI_IO1),
        .sck       (SPI_SCK),
        .mosi      (SPI_IO0_out),
        .rx_data   (rx_word),
        .busy      (busy),
        .done      (done)
    );

    // Next-state logic and shift-engine launch for the current phase
    always_comb begin
        // NOTE: every output of this block gets a default first so no
        // path through the case can leave one unassigned and infer a latch.
        state_next = state;
        start      = 1'b0;
        nbits      = BITS_WORD;
        tx_word    = '0;
        unique case (state)
            ST_WAKE: begin
                tx_word = {FLASH_CMD_WAKE, 24'h000000};
                nbits   = BITS_OPCODE;
                start   = !issued && !busy;
                if (done) state_next = ST_WAKE_WAIT;
            end
            ST_WAKE_WAIT: begin
                if (wait_cnt == WAIT_LAST) state_next = ST_CMD;
            end
            ST_CMD: begin
                tx_word = {FLASH_CMD_READ, FLASH_BASE};
                nbits   = BITS_CMD;
                start   = !issued && !busy;
                if (done) state_next = ST_DATA;
            end
            ST_DATA: begin
                start = !issued && !busy;
                if (done) begin
`ifdef BOOT_CHECKSUM_EN
                    if (trailer)
                        state_next = ((sum + rx_word) == 16'h0000) ? ST_DONE : ST_ERROR;
                    else
                        state_next = ST_WRITE;
`else
                    state_next = ST_WRITE;
`endif
                end
            end
            ST_WRITE: begin
`ifdef BOOT_CHECKSUM_EN
                state_next = ST_DATA;
`else
                state_next = is_last ? ST_DONE : ST_DATA;
`endif
            end
            ST_DONE:  state_next = ST_DONE;
            ST_ERROR: state_next = ST_ERROR;
            default:  state_next = ST_WAKE;
        endcase
    end

    // State register, launch flag, wake timer, write address/data and checksum
    always_ff @(posedge cpu_clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_WAKE;
            issued   <= 1'b0;
            wait_cnt <= '0;
            mem_addr <= '0;
            mem_data <= '0;
`ifdef BOOT_CHECKSUM_EN
            trailer  <= 1'b0;
            sum      <= '0;
`endif
        end else begin
            state    <= state_next;
            issued   <= (state_next != state) ? 1'b0 : (issued | start);
            wait_cnt <= (state == ST_WAKE_WAIT) ? wait_cnt + 16'd1 : 16'd0;
            if (state == ST_DATA && done && !trailer)
                mem_data <= rx_word;
            // the address saturates on the last word instead of wrapping
            if (state == ST_WRITE && !is_last)
                mem_addr <= mem_addr + MEM_ADDRESS_WIDTH'(1);
`ifdef BOOT_CHECKSUM_EN
            if (state == ST_WRITE) begin
                sum <= sum + mem_data;
                if (is_last) trailer <= 1'b1;
            end
`endif
        end
    end

    // CS stays low from the wake opcode launch, and across CMD/DATA/WRITE
    assign SPI_CS         = !((state == ST_WAKE && issued) || state == ST_CMD ||
                              state == ST_DATA || state == ST_WRITE);
    assign SPI_IO0_config = ~SPI_CS;
    assign mem_we         = (state == ST_WRITE);
    assign cpu_reset      = (state != ST_DONE);
    assign boot_done      = (state == ST_DONE);
`ifdef BOOT_CHECKSUM_EN
    assign boot_error     = (state == ST_ERROR);
`else
    assign boot_error     = 1'b0;
`endif

endmodule

// File: tb/tb_flash_boot_loader.sv
// Self-checking bench for flash_boot_loader: a byte-addressed SPI flash model,
// bus monitors, and directed boots with randomized images.
`timescale 1ns/1ps
module tb_flash_boot_loader;

    localparam int          AW     = 12;
    localparam logic [23:0] BASE   = 24'h100000;
    localparam int          WC     = 8;
    localparam int          DIV    = 3;
    localparam int          WAKE   = 16;
    localparam int          BUDGET = 6000;
`ifdef BOOT_CHECKSUM_EN
    localparam int          READ_BITS = 32 + 16 * (WC + 1);
`else
    localparam int          READ_BITS = 32 + 16 * WC;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;

    logic          cpu_clock = 1'b0;
    logic          reset     = 1'b0;
    logic          SPI_CS, SPI_SCK, SPI_IO0_out, SPI_IO0_config;
    logic          SPI_IO1   = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_data;
    logic          mem_we, cpu_reset, boot_done, boot_error;

    flash_boot_loader #(
        .MEM_ADDRESS_WIDTH (AW),
        .FLASH_BASE        (BASE),
        .WORD_COUNT        (WC),
        .SCK_DIV           (DIV),
        .WAKE_CYCLES       (WAKE)
    ) dut (
        .cpu_clock      (cpu_clock),
        .reset          (reset),
        .SPI_CS         (SPI_CS),
        .SPI_SCK        (SPI_SCK),
        .SPI_IO0_out    (SPI_IO0_out),
        .SPI_IO0_config (SPI_IO0_config),
        .SPI_IO1        (SPI_IO1),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_we         (mem_we),
        .cpu_reset      (cpu_reset),
        .boot_done      (boot_done),
        .boot_error     (boot_error)
    );

    always #5 cpu_clock = ~cpu_clock;

    // Flash contents (byte offset from BASE) and the image that produced them
    logic [7:0]  flash_mem [0:63];
    logic [15:0] img [0:WC];

    // Logs filled by the monitor
    wr_t         wr_q [$];
    logic [7:0]  mosi_q [$];
    int          cs_falls = 0, last_gap = 0, gap_cnt = 0, last_txn_bits = 0;
    int          per_min = 1000, per_max = 0;
    int          we_wide = 0, we_sck_bad = 0, mosi_bad = 0;

    int          n_checks = 0;
    int          n_fail   = 0;

    // Flash model and bus monitor, sampled mid-cycle away from the active edge
    initial begin : monitor
        logic        prev_cs, prev_sck, prev_we, prev_mosi;
        logic [31:0] cmd;
        logic [7:0]  cur;
        int          f_cnt, f_idx, cyc, last_rise, off;
        prev_cs = 1'b1; prev_sck = 1'b0; prev_we = 1'b0; prev_mosi = 1'b0;
        cmd = '0; cur = '0; f_cnt = 0; f_idx = 0; cyc = 0; last_rise = 0;
        forever begin
            @(negedge cpu_clock);
            cyc++;
            if (SPI_CS) begin
                if (!prev_cs) begin
                    gap_cnt       = 0;
                    last_txn_bits = f_cnt;
                end
                gap_cnt++;
                f_cnt = 0;
                f_idx = 0;
            end else begin
                if (prev_cs) begin
                    cs_falls++;
                    last_gap = gap_cnt;
                    f_cnt = 0; f_idx = 0; cur = '0; cmd = '0;
                end
                if (SPI_IO0_out !== prev_mosi && (SPI_SCK || (f_cnt > 0 && f_cnt < 32 && !prev_sck)))
                    mosi_bad++;
                if (SPI_SCK && !prev_sck) begin
                    if (f_cnt < 32) begin
                        cmd = {cmd[30:0], SPI_IO0_out};
                        cur = {cur[6:0], SPI_IO0_out};
                        if (f_cnt % 8 == 7) mosi_q.push_back(cur);
                        if (f_cnt >= 1) begin
                            if (cyc - last_rise < per_min) per_min = cyc - last_rise;
                            if (cyc - last_rise > per_max) per_max = cyc - last_rise;
                        end
                    end
                    last_rise = cyc;
                    f_cnt++;
                end
                if (!SPI_SCK && prev_sck && f_cnt >= 32) begin
                    off = int'(cmd[23:0]) - int'(BASE) + f_idx / 8;
                    if (cmd[31:24] == 8'h03 && off >= 0 && off < 64)
                        SPI_IO1 = flash_mem[off][7 - (f_idx % 8)];
                    else
                        SPI_IO1 = 1'b1;
                    f_idx++;
                end
            end
            if (mem_we) begin
                wr_q.push_back('{addr: mem_addr, data: mem_data});
                if (SPI_SCK) we_sck_bad++;
                if (prev_we) we_wide++;
            end
            prev_we   = mem_we;
            prev_cs   = SPI_CS;
            prev_sck  = SPI_SCK;
            prev_mosi = SPI_IO0_out;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string w);
        check({w, "_cs"},        32'(SPI_CS),         32'd1);
        check({w, "_sck"},       32'(SPI_SCK),        32'd0);
        check({w, "_io0"},       32'(SPI_IO0_out),    32'd0);
        check({w, "_io0_cfg"},   32'(SPI_IO0_config), 32'd0);
        check({w, "_addr"},      32'(mem_addr),       32'd0);
        check({w, "_data"},      32'(mem_data),       32'd0);
        check({w, "_we"},        32'(mem_we),         32'd0);
        check({w, "_cpu_reset"}, 32'(cpu_reset),      32'd1);
        check({w, "_done"},      32'(boot_done),      32'd0);
        check({w, "_error"},     32'(boot_error),     32'd0);
    endtask

    // Random image; trailer chosen so the word sum plus trailer is zero
    task automatic make_image();
        logic [15:0] s;
        s = '0;
        for (int i = 0; i < WC; i++) begin
            img[i] = 16'($urandom_range(1, 16'hFFFF));
            s = s + img[i];
        end
        img[WC] = -s;
    endtask

    task automatic load_image();
        for (int i = 0; i < 64; i++) flash_mem[i] = 8'hFF;
        for (int i = 0; i <= WC; i++) begin
            flash_mem[2*i]   = img[i][15:8];
            flash_mem[2*i+1] = img[i][7:0];
        end
    endtask

    task automatic wait_boot(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge cpu_clock);
            if (boot_done || boot_error) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_finished"}, 32'(ok), 32'd1);
        repeat (2) @(negedge cpu_clock);
    endtask

    task automatic check_writes(input int base, input string tag);
        check({tag, "_write_count"}, 32'(wr_q.size() - base), 32'(WC));
        for (int i = 0; i < WC && base + i < wr_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(wr_q[base+i].addr), 32'(i));
            check($sformatf("%s_data%0d", tag, i), 32'(wr_q[base+i].data), 32'(img[i]));
        end
    endtask

    task automatic reboot();
        reset = 1'b0;
        repeat (3) @(negedge cpu_clock);
        reset = 1'b1;
    endtask

    initial begin : stimulus
        int           base;
        logic [7:0]   exp_mosi [0:4];
        bit           ok;

        // Reset state
        repeat (3) @(negedge cpu_clock);
        check_reset_outputs("reset");

        // Boot 1: leading words 0x1234, 0xABCD, random remainder
        make_image();
        img[0] = 16'h1234;
        img[1] = 16'hABCD;
        img[WC] = img[WC] - 16'h1234 - 16'hABCD + 16'($urandom_range(1, 16'hFFFF));
        begin
            logic [15:0] s;
            s = '0;
            for (int i = 0; i < WC; i++) s = s + img[i];
            img[WC] = -s;
        end
        load_image();
        reset = 1'b1;
        wait_boot("boot1");
        check("boot1_done",      32'(boot_done),      32'd1);
        check("boot1_cpu_reset", 32'(cpu_reset),      32'd0);
        check("boot1_error",     32'(boot_error),     32'd0);
        check("boot1_cs_idle",   32'(SPI_CS),         32'd1);
        check("boot1_sck_idle",  32'(SPI_SCK),        32'd0);
        check("boot1_io0_cfg",   32'(SPI_IO0_config), 32'd0);
        check_writes(0, "boot1");

        exp_mosi[0] = 8'hAB; exp_mosi[1] = 8'h03;
        exp_mosi[2] = BASE[23:16]; exp_mosi[3] = BASE[15:8]; exp_mosi[4] = BASE[7:0];
        check("mosi_byte_count", 32'(mosi_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < mosi_q.size(); i++)
            check($sformatf("mosi_byte%0d", i), 32'(mosi_q[i]), 32'(exp_mosi[i]));
        check("cs_low_segments",  32'(cs_falls),      32'd2);
        check("wake_gap_cycles",  32'(last_gap),      32'(WAKE));
        check("sck_period_min",   32'(per_min),       32'(2 * (DIV + 1)));
        check("sck_period_max",   32'(per_max),       32'(2 * (DIV + 1)));
        check("read_txn_bits",    32'(last_txn_bits), 32'(READ_BITS));

        // Boot 2: reset after the third write, then a full reboot
        make_image();
        load_image();
        base = wr_q.size();
        reboot();
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge cpu_clock);
            #1;
            if (wr_q.size() >= base + 3) begin
                ok = 1'b1;
                break;
            end
        end
        check("third_write_seen", 32'(ok), 32'd1);
        check("mid_mem_data_live", 32'(mem_data), 32'(img[2]));
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (2) @(negedge cpu_clock);
        make_image();
        load_image();
        base = wr_q.size();
        reset = 1'b1;
        wait_boot("boot2");
        check("boot2_done", 32'(boot_done), 32'd1);
        check_writes(base, "boot2");

`ifdef BOOT_CHECKSUM_EN
        // Boot 3: words 1, 2, zeros, trailer 0xFFFD balances the sum
        for (int i = 0; i < WC; i++) img[i] = 16'h0000;
        img[0] = 16'h0001;
        img[1] = 16'h0002;
        img[WC] = 16'hFFFD;
        load_image();
        base = wr_q.size();
        reboot();
        wait_boot("boot3");
        check("ck_good_done",      32'(boot_done), 32'd1);
        check("ck_good_error",     32'(boot_error), 32'd0);
        check("ck_good_cpu_reset", 32'(cpu_reset), 32'd0);
        check_writes(base, "boot3");

        // Boot 4: same words, trailer 0x0000 is rejected
        img[WC] = 16'h0000;
        load_image();
        reboot();
        wait_boot("boot4");
        check("ck_bad_error",     32'(boot_error), 32'd1);
        check("ck_bad_done",      32'(boot_done),  32'd0);
        check("ck_bad_cpu_reset", 32'(cpu_reset),  32'd1);
        check("ck_bad_cs",        32'(SPI_CS),     32'd1);
        repeat (20) @(negedge cpu_clock);
        check("ck_bad_sticky",    32'(boot_error), 32'd1);
`endif

        // Protocol hygiene accumulated over every boot
        check("we_pulse_width",   32'(we_wide),    32'd0);
        check("we_with_sck_high", 32'(we_sck_bad), 32'd0);
        check("mosi_change_edge", 32'(mosi_bad),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
